// File: rtl/reg_file_sequencer.sv
// reg_file_sequencer
//   Instruction sequencer that drives a 4x8 register file. Takes 8-bit
//   instructions over a valid/ready handshake and runs each one as a short
//   multi-cycle FSM: IDLE -> EXEC -> WB for ALU/LI, IDLE -> EXEC -> OUT_WAIT for OUT.
//
// Ports
//   clk, reset                 clock; asynchronous active-low reset
//   instr_valid/instr_ready    instruction handshake; instr = {op,rs,rt,rd}, imm for LI
//   rf_read_reg1/2             register-file read addresses (set at accept, held)
//   rf_read_data1/2            combinational read data from the register file
//   rf_write/_reg/_data        register-file write port (rf_write high only in WB)
//   out_valid/out_ready/out_data  OUT result with back-pressure
//   flag_zero, flag_carry      status of the last ADD/SUB
//   retire_count               completed-instruction counter (wraps)
module reg_file_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        instr,
  input  logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] rf_read_reg1,
  output logic [ADDR_W-1:0] rf_read_reg2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic [7:0]        retire_count
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LI  = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, WB, OUT_WAIT} state_t;

  state_t            state, state_nxt;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W:0]   sum, diff, alu;

  // Extra top bit gives ADD carry-out; for SUB it is the borrow (rs < rt).
  assign sum  = {1'b0, rf_read_data1} + {1'b0, rf_read_data2};
  assign diff = {1'b0, rf_read_data1} - {1'b0, rf_read_data2};
  assign alu  = (op_q == OP_SUB) ? diff : sum;

  // Decoded from state so that an async reset in WB kills the write at once.
  assign instr_ready = (state == IDLE);
  assign rf_write    = (state == WB);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (instr_valid) state_nxt = EXEC;
      EXEC:     state_nxt = (op_q == OP_OUT) ? OUT_WAIT : WB;
      WB:       state_nxt = IDLE;
      OUT_WAIT: if (out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      op_q          <= OP_ADD;
      rd_q          <= '0;
      imm_q         <= '0;
      rf_read_reg1  <= '0;
      rf_read_reg2  <= '0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      flag_zero     <= 1'b0;
      flag_carry    <= 1'b0;
      retire_count  <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (instr_valid) begin
          // Read addresses are loaded at accept so they are valid for the
          // whole EXEC cycle, and simply hold afterwards.
          op_q         <= instr[7:6];
          rf_read_reg1 <= instr[5:4];
          rf_read_reg2 <= instr[3:2];
          rd_q         <= instr[1:0];
          imm_q        <= imm;
        end
        EXEC: begin
          if (op_q == OP_OUT) begin
            out_data  <= rf_read_data1;
            out_valid <= 1'b1;
          end else begin
            // rf_write_data doubles as the result register presented in WB.
            rf_write_reg  <= rd_q;
            rf_write_data <= (op_q == OP_LI) ? imm_q : alu[DATA_W-1:0];
            if (op_q != OP_LI) begin
              flag_zero  <= (alu[DATA_W-1:0] == '0);
              flag_carry <= alu[DATA_W];
            end
          end
        end
        WB: retire_count <= retire_count + 8'd1;
        OUT_WAIT: if (out_ready) begin
          out_valid    <= 1'b0;
          retire_count <= retire_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Scoreboard bench for reg_file_sequencer. Hosts a behavioural register file,
// keeps an instruction-level reference model, and checks every register write
// and every OUT handshake from a monitor that is independent of the stimulus.
module tb_reg_file_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] instr = '0;
  logic [7:0] imm = '0;
  logic [1:0] rf_read_reg1, rf_read_reg2, rf_write_reg;
  logic [7:0] rf_read_data1, rf_read_data2, rf_write_data;
  logic       rf_write;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       flag_zero, flag_carry;
  logic [7:0] retire_count;

  reg_file_sequencer #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .imm(imm),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .rf_write(rf_write), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  // Environment register file: combinational reads, write on the clock edge.
  logic [7:0] rf [4];
  initial for (int i = 0; i < 4; i++) rf[i] = '0;
  assign rf_read_data1 = rf[rf_read_reg1];
  assign rf_read_data2 = rf[rf_read_reg2];
  always @(posedge clk) if (rf_write) rf[rf_write_reg] <= rf_write_data;

  // Reference model state.
  int unsigned m [4];
  int unsigned exp_z = 0, exp_c = 0, exp_ret = 0;
  int unsigned wq [$];   // expected writes: rd*256 + data
  int unsigned oq [$];   // expected OUT values

  int total = 0, bad = 0;
  bit rand_rdy = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or an OUT handshake.
  always @(negedge clk) if (reset) begin
    if (rf_write) begin
      if (wq.size() == 0) chk("unexpected_write", {22'd0, rf_write_reg, rf_write_data}, 32'hFFFF_FFFF);
      else chk("write", {22'd0, rf_write_reg, rf_write_data}, wq.pop_front());
    end
    if (out_valid && out_ready) begin
      if (oq.size() == 0) chk("unexpected_out", out_data, 32'hFFFF_FFFF);
      else chk("out_data", out_data, oq.pop_front());
    end
  end

  always @(posedge clk) if (rand_rdy) begin
    #1 out_ready = 1'($urandom_range(0, 1));
  end

  // Instruction-level model: what the architectural state should become.
  task automatic model(input int op, input int rs, input int rt, input int rd, input int unsigned iv);
    int unsigned a, b, r;
    a = m[rs]; b = m[rt];
    case (op)
      0: begin r = a + b; exp_c = (r > 255); r = r % 256; exp_z = (r == 0); end
      1: begin exp_c = (a < b); r = (a + 256 - b) % 256; exp_z = (r == 0); end
      2: r = iv;
      default: r = 0;
    endcase
    if (op == 3) oq.push_back(a);
    else begin m[rd] = r; wq.push_back(rd * 256 + r); end
    exp_ret = (exp_ret + 1) % 256;
  endtask

  // Waits (bounded) for instr_ready, presents one instruction for one accept edge.
  task automatic issue(input int op, input int rs, input int rt, input int rd,
                       input int unsigned iv, input bit track);
    int n = 0;
    while (!instr_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) chk("ready_timeout", 0, 1);
    instr = {2'(op), 2'(rs), 2'(rt), 2'(rd)};
    imm = 8'(iv);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (track) model(op, rs, rt, rd, iv);
  endtask

  task automatic wait_idle_check(input string tag);
    int n = 0;
    while (!instr_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) chk({tag, "_idle_timeout"}, 0, 1);
    chk({tag, "_zero"}, flag_zero, exp_z);
    chk({tag, "_carry"}, flag_carry, exp_c);
    chk({tag, "_retire"}, retire_count, exp_ret);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rf_write"}, rf_write, 0);
    chk({tag, "_wr_reg_data"}, {rf_write_reg, rf_write_data}, 0);
    chk({tag, "_out"}, {out_valid, out_data}, 0);
    chk({tag, "_flags"}, {flag_zero, flag_carry}, 0);
    chk({tag, "_retire"}, retire_count, 0);
    chk({tag, "_rd_addr"}, {rf_read_reg1, rf_read_reg2}, 0);
    chk({tag, "_ready"}, instr_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m[i] = 0;
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // LI r2=0x55 with exact write timing, then OUT r2.
    issue(2, 0, 0, 2, 8'h55, 1);
    chk("li_exec_no_write", rf_write, 0);
    @(posedge clk); #1;
    chk("li_wb_pulse", {rf_write, rf_write_reg, rf_write_data}, {1'b1, 2'd2, 8'h55});
    @(posedge clk); #1;
    chk("li_pulse_end", rf_write, 0);
    chk("li_ready", instr_ready, 1);
    issue(3, 2, 0, 0, 0, 1);
    chk("out_not_yet", out_valid, 0);
    @(posedge clk); #1;
    chk("out_rise", {out_valid, out_data}, {1'b1, 8'h55});
    @(posedge clk); #1;
    chk("retire_two", retire_count, 2);

    // ADD with carry.
    issue(2, 0, 0, 0, 8'hF0, 1);
    issue(2, 0, 0, 1, 8'h20, 1);
    issue(0, 0, 1, 3, 0, 1);
    wait_idle_check("add");
    chk("add_carry_const", {flag_carry, flag_zero}, 2'b10);
    issue(3, 3, 0, 0, 0, 1);
    wait_idle_check("out_r3");

    // SUB to zero, then SUB with borrow.
    issue(2, 0, 0, 1, 8'h33, 1);
    issue(1, 1, 1, 2, 0, 1);
    wait_idle_check("sub_zero");
    chk("sub_zero_const", {flag_carry, flag_zero}, 2'b01);
    issue(1, 2, 1, 0, 0, 1);
    wait_idle_check("sub_borrow");
    chk("sub_borrow_const", {flag_carry, flag_zero}, 2'b10);

    // OUT r0 under back-pressure; a stray instruction must be ignored.
    out_ready = 1'b0;
    issue(3, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_out", {out_valid, out_data}, {1'b1, 8'hCD});
      chk("stall_ready", instr_ready, 0);
      instr = {2'd2, 2'd0, 2'd0, 2'd3}; imm = 8'hAA; instr_valid = 1'b1;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", {out_valid, instr_ready}, 2'b01);
    chk("stall_retire", retire_count, exp_ret);

    // Reset in the middle of WB: the write is dropped.
    issue(0, 0, 1, 3, 0, 0);
    @(posedge clk); #1;
    chk("midwb_write_high", rf_write, 1);
    reset = 1'b0;
    #1 check_reset_outputs("midwb");
    exp_z = 0; exp_c = 0; exp_ret = 0;
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("midwb_r3_kept", rf[3], m[3]);

    // 256 instructions wrap the retire counter back to 0.
    for (int i = 0; i < 256; i++) issue(2, 0, 0, i % 4, $urandom_range(0, 255), 1);
    wait_idle_check("wrap");
    chk("wrap_zero", retire_count, 0);

    // rd aliases rs/rt: r1 doubles three times.
    issue(2, 0, 0, 1, 8'h01, 1);
    for (int i = 0; i < 3; i++) issue(0, 1, 1, 1, 0, 1);
    wait_idle_check("alias");
    issue(3, 1, 0, 0, 0, 1);
    wait_idle_check("alias_out");
    chk("alias_r1", rf[1], 8'h08);

    // Random mix with random back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      issue($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 255), 1);
      if (i % 8 == 7) wait_idle_check("rand");
    end
    wait_idle_check("rand_end");
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("wq_drained", wq.size(), 0);
    chk("oq_drained", oq.size(), 0);
    for (int i = 0; i < 4; i++) chk("final_reg", rf[i], m[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_sequencer.md
Name: reg_file_sequencer

Overview:
- Initiator side of the 4x8 register-file interface: drives the read-address, write-enable, write-address and write-data lines of the register file; receives its two combinational read-data lines.
- Accepts 8-bit instructions over a valid/ready handshake and executes them as a multi-cycle FSM.
- Supported operations: ADD, SUB, load-immediate, and register output with back-pressure.
- Sits between the instruction source (fetch/test driver) and the register file in the microprocessor datapath.

Parameters:
- DATA_W, 8, register and data width.
- ADDR_W, 2, register address width (4 registers).

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- instr_valid  input  1  instruction and imm are valid.
- instr_ready  output  1  sequencer can accept an instruction.
- instr  input  8  [7:6] op, [5:4] rs, [3:2] rt, [1:0] rd.
- imm  input  DATA_W  immediate for LI; sampled together with instr.
- rf_read_reg1  output  ADDR_W  register-file read port 1 address.
- rf_read_reg2  output  ADDR_W  register-file read port 2 address.
- rf_read_data1  input  DATA_W  combinational read data, port 1.
- rf_read_data2  input  DATA_W  combinational read data, port 2.
- rf_write  output  1  register-file write enable.
- rf_write_reg  output  ADDR_W  write address.
- rf_write_data  output  DATA_W  write data.
- out_valid  output  1  out_data holds a register value from an OUT instruction.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  DATA_W  value read by OUT.
- flag_zero  output  1  last ADD/SUB result was 0.
- flag_carry  output  1  ADD carry-out, or SUB borrow (rs < rt unsigned).
- retire_count  output  8  count of completed instructions; wraps 255 -> 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - State -> IDLE.
  - rf_write=0, out_valid=0.
  - out_data, rf_write_data, rf_write_reg, flags, retire_count = 0.
  - Read addresses = 0.
  - A pending write is dropped immediately; there is no partial write.
- Opcodes: 00 ADD rd=rs+rt; 01 SUB rd=rs-rt; 10 LI rd=imm; 11 OUT out_data=rs.
- FSM states: IDLE, EXEC, WB, OUT_WAIT.
- IDLE:
  - instr_ready=1.
  - On an edge with instr_valid=1: latch instr and imm, go to EXEC.
  - Otherwise hold.
- EXEC (one cycle):
  - rf_read_reg1=rs, rf_read_reg2=rt.
  - ADD/SUB: compute DATA_W+1-bit result; store the low DATA_W bits in result_q; update flag_zero and flag_carry at the edge.
  - LI: result_q=imm; flags unchanged.
  - ADD/SUB/LI: next state WB.
  - OUT: at the edge, out_data<=rf_read_data1, out_valid<=1, go to OUT_WAIT; flags unchanged.
- WB (one cycle):
  - rf_write=1, rf_write_reg=rd, rf_write_data=result_q.
  - Register file captures on the edge ending WB.
  - retire_count increments; go to IDLE.
- OUT_WAIT:
  - out_valid=1 and out_data held stable until out_ready=1 is sampled.
  - On that edge: out_valid<=0, retire_count increments, go to IDLE.
  - out_ready=1 while out_valid=0 has no effect.
- rf_write is asserted only in WB; it is 0 in every other state.
- Read addresses hold their last EXEC values outside EXEC.
- instr_ready=0 outside IDLE; instr_valid is ignored there.
- Latency, acceptance edge to register-file update: ADD/SUB/LI take 2 cycles (EXEC, WB); next accept is possible in the cycle after WB.
- Throughput: one ALU instruction per 3 cycles.
- Minimum latency for OUT: out_valid rises 2 edges after acceptance.
- rd equal to rs or rt: operands are read in EXEC, before the WB write, so the old values are used.
- Back-to-back dependent instructions see the written value, because the write completes before the next EXEC.
- Arithmetic is unsigned modulo 2^DATA_W. SUB borrow = 1 when rs < rt.

Test Plan:
- Reset, then LI r2=0x55, then OUT r2 -> rf_write pulses exactly 1 cycle with reg=2, data=0x55; out_valid rises with out_data=0x55; retire_count=2.
- LI r0=0xF0, LI r1=0x20, ADD r3=r0+r1 -> r3=0x10, flag_carry=1, flag_zero=0; OUT r3 gives 0x10.
- LI r1=0x33, SUB r2=r1-r1 -> r2=0x00, flag_zero=1, flag_carry=0; then SUB r0=r2-r1 -> 0xCD, carry(borrow)=1, zero=0.
- OUT r0 with out_ready=0 for 5 cycles -> out_valid and out_data stable, instr_ready=0, a presented instr_valid is ignored; out_ready=1 -> retire on that edge, IDLE next cycle.
- Assert reset=0 mid-WB of ADD -> rf_write drops to 0 combinationally with reset, no write edge occurs, all outputs return to reset values, instr_ready=1 after release.
- Issue 256 LI instructions -> retire_count wraps to 0; rd=rs aliasing check: LI r1=0x01, ADD r1=r1+r1 repeated 3 times -> r1=0x08.
